// File: rtl/de0_cv_fd_seg.sv
// DE0-CV frequency-divider demo: a switch-selected prescaler makes a slow clock,
// whose rising edges step an 8-bit counter shown on LEDs and 7-segment displays.
module de0_cv_fd_seg #(
  parameter int DIV0 = 25_000_000,
  parameter int DIV1 = 12_500_000,
  parameter int DIV2 = 5_000_000,
  parameter int DIV3 = 2_500_000
) (
  input  logic       CLOCK_50,
  input  logic       RESET_N,
  input  logic       CLOCK2_50,
  input  logic       CLOCK3_50,
  input  logic       CLOCK4_50,
  input  logic [3:0] KEY,
  input  logic [9:0] SW,
  output logic [9:0] LEDR,
  output logic [6:0] HEX0,
  output logic [6:0] HEX1,
  output logic [6:0] HEX2,
  output logic [6:0] HEX3,
  output logic [6:0] HEX4,
  output logic [6:0] HEX5
);

  localparam logic [24:0] DIV0_M1 = 25'(DIV0 - 1);
  localparam logic [24:0] DIV1_M1 = 25'(DIV1 - 1);
  localparam logic [24:0] DIV2_M1 = 25'(DIV2 - 1);
  localparam logic [24:0] DIV3_M1 = 25'(DIV3 - 1);
  localparam logic [6:0]  SEG_BLANK = 7'h7F;

  function automatic logic [6:0] seg7(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      4'hF: s = 7'h0E;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  logic [1:0]  sync1_q, sel_q, prev_sel_q;
  logic [24:0] cnt_q, cnt_d;
  logic        clk_div_q, clk_div_d;
  logic        tick_q, tick_d;
  logic [7:0]  q_q, q_d;
  logic [24:0] n_m1_s;
  logic        unused_ok;

  assign unused_ok = ^{CLOCK2_50, CLOCK3_50, CLOCK4_50, KEY, SW[9:2]};

  // terminal count for the currently synchronized ratio select
  always_comb begin
    case (sel_q)
      2'd0:    n_m1_s = DIV0_M1;
      2'd1:    n_m1_s = DIV1_M1;
      2'd2:    n_m1_s = DIV2_M1;
      2'd3:    n_m1_s = DIV3_M1;
      default: n_m1_s = DIV0_M1;
    endcase
  end

  // a ratio change restarts the prescaler so a stale count is never compared
  always_comb begin
    cnt_d     = cnt_q + 25'd1;
    clk_div_d = clk_div_q;
    tick_d    = 1'b0;
    q_d       = q_q + {7'd0, tick_q};
    if (sel_q != prev_sel_q) begin
      cnt_d = 25'd0;
    end else if (cnt_q == n_m1_s) begin
      cnt_d     = 25'd0;
      clk_div_d = ~clk_div_q;
      tick_d    = ~clk_div_q;
    end else begin
      cnt_d = cnt_q + 25'd1;
    end
  end

  // all state, with synchronous active-high reset
  always_ff @(posedge CLOCK_50) begin
    if (RESET_N) begin
      sync1_q    <= 2'd0;
      sel_q      <= 2'd0;
      prev_sel_q <= 2'd0;
      cnt_q      <= 25'd0;
      clk_div_q  <= 1'b0;
      tick_q     <= 1'b0;
      q_q        <= 8'd0;
    end else begin
      sync1_q    <= SW[1:0];
      sel_q      <= sync1_q;
      prev_sel_q <= sel_q;
      cnt_q      <= cnt_d;
      clk_div_q  <= clk_div_d;
      tick_q     <= tick_d;
      q_q        <= q_d;
    end
  end

  assign LEDR = {clk_div_q, tick_q, q_q};
  assign HEX0 = seg7(q_q[3:0]);
  assign HEX1 = seg7(q_q[7:4]);
  assign HEX2 = SEG_BLANK;
  assign HEX3 = SEG_BLANK;
  assign HEX4 = seg7({2'b00, prev_sel_q});
  assign HEX5 = SEG_BLANK;

endmodule

// File: tb/tb_de0_cv_fd_seg.sv
// Directed testbench for de0_cv_fd_seg with small divide ratios (10/5/2/1).
module tb_de0_cv_fd_seg;

  logic       CLOCK_50 = 1'b0;
  logic       RESET_N  = 1'b1;
  logic       CLOCK2_50 = 1'b0, CLOCK3_50 = 1'b0, CLOCK4_50 = 1'b0;
  logic [3:0] KEY = 4'd0;
  logic [9:0] SW  = 10'd0;
  logic [9:0] LEDR;
  logic [6:0] HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;

  int tests_run = 0;
  int tests_failed = 0;
  int e = 0;

  de0_cv_fd_seg #(.DIV0(10), .DIV1(5), .DIV2(2), .DIV3(1)) dut (
    .CLOCK_50(CLOCK_50), .RESET_N(RESET_N),
    .CLOCK2_50(CLOCK2_50), .CLOCK3_50(CLOCK3_50), .CLOCK4_50(CLOCK4_50),
    .KEY(KEY), .SW(SW), .LEDR(LEDR),
    .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2), .HEX3(HEX3), .HEX4(HEX4), .HEX5(HEX5)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic step();
    @(posedge CLOCK_50);
    #1;
    e = e + 1;
  endtask

  // Expected LEDR e edges after reset release with SW[1:0]=00 and N=10
  function automatic logic [9:0] exp_div0(input int k);
    logic       cd, tk;
    logic [7:0] qq;
    cd = ((k / 10) % 2) == 1;
    tk = (k % 20) == 10;
    qq = (k >= 11) ? 8'((k - 11) / 20 + 1) : 8'd0;
    return {cd, tk, qq};
  endfunction

  task automatic test_reset();
    RESET_N = 1'b1;
    SW = 10'd0;
    repeat (3) step();
    tests_run++;
    if (LEDR !== 10'd0) begin
      tests_failed++;
      $display("FAIL reset_ledr: got %h want 000", LEDR);
    end
    tests_run++;
    if ({HEX0, HEX1, HEX4} !== {7'h40, 7'h40, 7'h40}) begin
      tests_failed++;
      $display("FAIL reset_hex014: got %h %h %h want 40 40 40", HEX0, HEX1, HEX4);
    end
    tests_run++;
    if ({HEX2, HEX3, HEX5} !== {7'h7F, 7'h7F, 7'h7F}) begin
      tests_failed++;
      $display("FAIL reset_hex235: got %h %h %h want 7f 7f 7f", HEX2, HEX3, HEX5);
    end
    RESET_N = 1'b0;
    e = 0;
  endtask

  task automatic test_div0();
    logic [9:0] ex;
    for (int i = 1; i <= 400; i++) begin
      step();
      ex = exp_div0(e);
      tests_run++;
      if (LEDR !== ex) begin
        tests_failed++;
        $display("FAIL div0_ledr e=%0d: got %h want %h", e, LEDR, ex);
      end
    end
    tests_run++;
    if ({HEX1, HEX0, HEX4} !== {7'h79, 7'h19, 7'h40}) begin
      tests_failed++;
      $display("FAIL div0_hex_q20: got %h %h %h want 79 19 40", HEX1, HEX0, HEX4);
    end
  endtask

  // SW to 01 when cnt=7 (edge 407); clear lands on edge 410
  task automatic test_ratio_change();
    repeat (7) step();
    SW = 10'b00_0000_0001;
    step(); step();
    tests_run++;
    if (HEX4 !== 7'h40) begin
      tests_failed++;
      $display("FAIL chg_hex4_early: got %h want 40", HEX4);
    end
    step();
    tests_run++;
    if (HEX4 !== 7'h79 || LEDR[9] !== 1'b0) begin
      tests_failed++;
      $display("FAIL chg_at_clear: hex4 %h clkdiv %b want 79 0", HEX4, LEDR[9]);
    end
    repeat (4) step();
    tests_run++;
    if (LEDR[9:8] !== 2'b00) begin
      tests_failed++;
      $display("FAIL chg_no_early_toggle: got %b want 00", LEDR[9:8]);
    end
    step();
    tests_run++;
    if (LEDR !== {2'b11, 8'd20}) begin
      tests_failed++;
      $display("FAIL chg_first_toggle: got %h want %h", LEDR, {2'b11, 8'd20});
    end
    step();
    tests_run++;
    if (LEDR !== {2'b10, 8'd21}) begin
      tests_failed++;
      $display("FAIL chg_q21: got %h want %h", LEDR, {2'b10, 8'd21});
    end
    repeat (4) step();
    tests_run++;
    if (LEDR !== {2'b00, 8'd21}) begin
      tests_failed++;
      $display("FAIL chg_fall: got %h want %h", LEDR, {2'b00, 8'd21});
    end
    repeat (5) step();
    tests_run++;
    if (LEDR !== {2'b11, 8'd21}) begin
      tests_failed++;
      $display("FAIL chg_period10: got %h want %h", LEDR, {2'b11, 8'd21});
    end
    step();
  endtask

  // N=1: from edge 430 clk_div toggles every edge, tick every 2nd edge
  task automatic test_div3_wrap();
    logic [9:0] ex;
    logic       cd;
    SW = 10'b00_0000_0011;
    repeat (3) step();
    tests_run++;
    if (HEX4 !== 7'h30) begin
      tests_failed++;
      $display("FAIL div3_hex4: got %h want 30", HEX4);
    end
    while (e < 1009) begin
      step();
      cd = ((e - 430) % 2) == 1;
      ex = {cd, cd, 8'((22 + (e - 430) / 2) % 256)};
      tests_run++;
      if (LEDR !== ex) begin
        tests_failed++;
        $display("FAIL div3_ledr e=%0d: got %h want %h", e, LEDR, ex);
      end
      if (e == 896) begin
        tests_run++;
        if ({HEX1, HEX0} !== {7'h0E, 7'h0E}) begin
          tests_failed++;
          $display("FAIL div3_hex_ff: got %h %h want 0e 0e", HEX1, HEX0);
        end
      end
      if (e == 898) begin
        tests_run++;
        if ({HEX1, HEX0} !== {7'h40, 7'h40}) begin
          tests_failed++;
          $display("FAIL div3_hex_wrap: got %h %h want 40 40", HEX1, HEX0);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    tests_run++;
    if (LEDR[9] !== 1'b1 || LEDR[7:0] !== 8'h37) begin
      tests_failed++;
      $display("FAIL rst_mid_pre: got %h want clkdiv 1 q 37", LEDR);
    end
    RESET_N = 1'b1;
    SW = 10'd0;
    step();
    tests_run++;
    if (LEDR !== 10'd0) begin
      tests_failed++;
      $display("FAIL rst_mid_ledr: got %h want 000", LEDR);
    end
    tests_run++;
    if ({HEX0, HEX1, HEX4} !== {7'h40, 7'h40, 7'h40}) begin
      tests_failed++;
      $display("FAIL rst_mid_hex: got %h %h %h want 40 40 40", HEX0, HEX1, HEX4);
    end
    step();
    RESET_N = 1'b0;
    e = 0;
  endtask

  task automatic test_ignored_inputs();
    logic [9:0] ex;
    for (int i = 1; i <= 60; i++) begin
      SW = {8'($urandom), 2'b00};
      KEY = 4'($urandom);
      CLOCK2_50 = 1'($urandom);
      CLOCK3_50 = 1'($urandom);
      CLOCK4_50 = 1'($urandom);
      step();
      ex = exp_div0(e);
      tests_run++;
      if (LEDR !== ex || {HEX2, HEX3, HEX4, HEX5} !== {7'h7F, 7'h7F, 7'h40, 7'h7F}) begin
        tests_failed++;
        $display("FAIL ignored_in e=%0d: ledr %h hex2345 %h %h %h %h want %h 7f 7f 40 7f",
                 e, LEDR, HEX2, HEX3, HEX4, HEX5, ex);
      end
    end
  endtask

  initial begin
    test_reset();
    test_div0();
    test_ratio_change();
    test_div3_wrap();
    test_reset_mid();
    test_ignored_inputs();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
